display_scan_controller: RTL and testbench

Time-multiplexed scan controller that shares one `seven_segment_driver` decoder between `N_DIGITS` common-anode digits. It holds a frame of BCD digits and cycles the shared decoder input through them, one digit slot at a time. It drives active-low digit enables with a ghosting blank interval at the start of each slot. New frames arrive through a valid/ready handshake and are committed only at frame boundaries, so the display never tears.

---
 rtl/display_scan_controller.sv | 112 +++++++++++
 tb/tb_display_scan_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Time-multiplexed BCD scan controller for one shared seven-segment decoder.
// Optional build macro LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module display_scan_controller #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*N_DIGITS-1:0] load_data,
  output logic [3:0]            digit_code,
  output logic [N_DIGITS-1:0]   digit_sel
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic {SCAN_BLANK, SCAN_ON} scan_state_e;

  scan_state_e           state, state_next;
  logic [PW-1:0]         prescaler, prescaler_next;
  logic [IW-1:0]         index, index_next;
  logic [4*N_DIGITS-1:0] display_reg, display_next;
  logic [4*N_DIGITS-1:0] pending_reg, pending_next;
  logic                  pending_full, pending_full_next;
  logic [3:0]            digit_code_next;
  logic [N_DIGITS-1:0]   digit_sel_next;
  logic                  slot_end, frame_end, shown;

  assign load_ready = !pending_full && !rst;

  // Outputs are computed from next-state values so the registered outputs line up
  // with the slot that the counters are entering.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_next        = state;
    prescaler_next    = prescaler + 1'b1;
    index_next        = index;
    display_next      = display_reg;
    pending_next      = pending_reg;
    pending_full_next = pending_full;
    digit_code_next   = 4'd0;
    digit_sel_next    = '1;
    shown             = 1'b1;

    slot_end  = (prescaler == PRE_LAST);
    frame_end = slot_end && (index == IDX_LAST);

    if (slot_end) begin
      prescaler_next = '0;
      state_next     = SCAN_BLANK;
      index_next     = (index == IDX_LAST) ? '0 : index + 1'b1;
    end else if (prescaler == BLANK_LAST) begin
      state_next = SCAN_ON;
    end

    // Commit uses the pending flag from before this edge, so a load landing on
    // the boundary waits a full frame.
    if (frame_end && pending_full) begin
      display_next      = pending_reg;
      pending_full_next = 1'b0;
    end

    if (load_valid && load_ready) begin
      pending_next      = load_data;
      pending_full_next = 1'b1;
    end

    for (int i = 0; i < N_DIGITS; i++)
      if (index_next == IW'(i)) digit_code_next = display_next[4*i +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    shown = (index_next == '0);
    for (int i = 0; i < N_DIGITS; i++)
      if (display_next[4*i +: 4] != 4'd0 && IW'(i) >= index_next) shown = 1'b1;
`else
    shown = 1'b1;
`endif

    if (state_next == SCAN_ON && shown) digit_sel_next[index_next] = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state        <= SCAN_BLANK;
      prescaler    <= '0;
      index        <= '0;
      // NOTE: the frame registers are reset so that a reset discards any shown or pending frame.
      display_reg  <= '0;
      pending_reg  <= '0;
      pending_full <= 1'b0;
      digit_code   <= 4'd0;
      digit_sel    <= '1;
    end else begin
      state        <= state_next;
      prescaler    <= prescaler_next;
      index        <= index_next;
      display_reg  <= display_next;
      pending_reg  <= pending_next;
      pending_full <= pending_full_next;
      digit_code   <= digit_code_next;
      digit_sel    <= digit_sel_next;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// Stimulus pushes time-stamped expectations; a negedge monitor pops and compares them.
module tb_display_scan_controller;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = N * RD;

  localparam int K_CODE  = 0;
  localparam int K_SEL   = 1;
  localparam int K_READY = 2;

  logic            clk;
  logic            rst;
  logic            load_valid;
  logic            load_ready;
  logic [4*N-1:0]  load_data;
  logic [3:0]      digit_code;
  logic [N-1:0]    digit_sel;

  display_scan_controller #(.N_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .digit_code (digit_code),
    .digit_sel  (digit_sel)
  );

  typedef struct {
    int         t;
    int         kind;
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   tick = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tick <= tick + 1;

  // Monitor: compare every expectation due in the current cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].t <= tick) begin
        exp_t it;
        logic [3:0] act;
        it = q.pop_front();
        case (it.kind)
          K_CODE:  act = digit_code;
          K_SEL:   act = digit_sel;
          default: act = {3'b000, load_ready};
        endcase
        n_tests++;
        if (it.t < tick) begin
          n_fail++;
          $display("FAIL %s: expectation for tick %0d missed (now %0d)", it.name, it.t, tick);
        end else if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %b, expected %b (tick %0d)", it.name, act, it.exp, tick);
        end
      end
    end
  end

  task automatic expect_at(input int t, input int kind, input logic [3:0] v, input string nm);
    exp_t it;
    int idx;
    it.t = t; it.kind = kind; it.exp = v; it.name = nm;
    idx = q.size();
    while (idx > 0 && q[idx-1].t > t) idx--;
    q.insert(idx, it);
  endtask

  function automatic bit digit_shown(input logic [15:0] d, input int s);
`ifdef LEADING_ZERO_BLANK_EN
    if (s == 0) return 1'b1;
    for (int i = s; i < N; i++) if (d[4*i +: 4] != 4'd0) return 1'b1;
    return 1'b0;
`else
    return 1'b1;
`endif
  endfunction

  // Expected view of one full frame starting at absolute tick t0.
  task automatic push_frame(input int t0, input logic [15:0] d, input string tag);
    logic [3:0] on_sel;
    for (int s = 0; s < N; s++) begin
      on_sel = digit_shown(d, s) ? ~(4'b0001 << s) : 4'b1111;
      expect_at(t0 + s*RD,          K_CODE, d[4*s +: 4], $sformatf("%s_code_s%0d_start", tag, s));
      expect_at(t0 + s*RD + RD - 1, K_CODE, d[4*s +: 4], $sformatf("%s_code_s%0d_end", tag, s));
      expect_at(t0 + s*RD,          K_SEL,  4'b1111,     $sformatf("%s_sel_s%0d_blank0", tag, s));
      expect_at(t0 + s*RD + BC - 1, K_SEL,  4'b1111,     $sformatf("%s_sel_s%0d_blank1", tag, s));
      expect_at(t0 + s*RD + BC,     K_SEL,  on_sel,      $sformatf("%s_sel_s%0d_on", tag, s));
      expect_at(t0 + s*RD + RD - 1, K_SEL,  on_sel,      $sformatf("%s_sel_s%0d_last", tag, s));
    end
  endtask

  task automatic goto(input int t);
    while (tick < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int base, input string tag);
    expect_at(tick, K_READY, 4'd0, {tag, "_ready_in_rst"});
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = tick;
  endtask

  task automatic load_at(input int t, input logic [15:0] d);
    goto(t);
    load_valid = 1'b1;
    load_data  = d;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = 16'h0;
  endtask

  int b, b2;
  int budget;

  initial begin
    rst = 1'b1;
    load_valid = 1'b0;
    load_data = 16'h0;
    @(posedge clk);
    #1;

    // Idle after reset: zeros, blanking pattern, wrap at cycle 32.
    do_reset(b, "idle");
    expect_at(b, K_READY, 4'd1, "idle_ready_c0");
    push_frame(b, 16'h0000, "idle_f0");
    expect_at(b + 32, K_SEL, 4'b1111, "idle_wrap_blank");
    expect_at(b + 34, K_SEL, 4'b1110, "idle_wrap_on");
    goto(b + 40);

    // Load 0x1234 at cycle 3: visible from cycle 32.
    do_reset(b, "l1234");
    expect_at(b + 3,  K_READY, 4'd1, "l1234_ready_c3");
    expect_at(b + 4,  K_READY, 4'd0, "l1234_ready_c4");
    expect_at(b + 31, K_READY, 4'd0, "l1234_ready_c31");
    expect_at(b + 33, K_READY, 4'd1, "l1234_ready_c33");
    push_frame(b, 16'h0000, "l1234_f0");
    push_frame(b + FRAME, 16'h1234, "l1234_f1");
    load_at(b + 3, 16'h1234);
    goto(b + 2*FRAME);

    // Transfer on the frame boundary: captured, committed one frame later.
    do_reset(b, "l5678");
    expect_at(b + 32, K_READY, 4'd0, "l5678_ready_c32");
    expect_at(b + 63, K_READY, 4'd0, "l5678_ready_c63");
    expect_at(b + 65, K_READY, 4'd1, "l5678_ready_c65");
    push_frame(b + FRAME, 16'h0000, "l5678_f1");
    push_frame(b + 2*FRAME, 16'h5678, "l5678_f2");
    load_at(b + 31, 16'h5678);
    goto(b + 3*FRAME);

    // Back-to-back loads: second stalls until the first commits.
    do_reset(b, "b2b");
    push_frame(b + FRAME, 16'h1111, "b2b_f1");
    push_frame(b + 2*FRAME, 16'h2222, "b2b_f2");
    load_at(b + 3, 16'h1111);
    load_valid = 1'b1;
    load_data  = 16'h2222;
    budget = 100;
    while (!load_ready && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    n_tests++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL b2b_stall_timeout: load_ready=%b after 100 cycles, expected 1", load_ready);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    goto(b + 3*FRAME);

    // Reset mid-frame with a pending frame: pending data never appears.
    do_reset(b, "rstmid");
    expect_at(b + 4,  K_READY, 4'd0,    "rstmid_ready_pending");
    expect_at(b + 10, K_SEL,   4'b1101, "rstmid_sel_c10");
    load_at(b + 3, 16'h9876);
    goto(b + 20);
    do_reset(b2, "rstmid2");
    expect_at(b2, K_READY, 4'd1, "rstmid_ready_after");
    push_frame(b2, 16'h0000, "rstmid_f0");
    push_frame(b2 + FRAME, 16'h0000, "rstmid_f1");
    goto(b2 + 2*FRAME);

    // Leading zeros (blanked only when the option is built in), then all zeros.
    do_reset(b, "lz");
    push_frame(b + FRAME, 16'h0042, "lz42_f1");
    push_frame(b + 2*FRAME, 16'h0000, "lz00_f2");
    load_at(b + 3, 16'h0042);
    load_at(b + 40, 16'h0000);
    goto(b + 3*FRAME);

    // Codes 10..15 pass through unchanged.
    do_reset(b, "hex");
    push_frame(b + FRAME, 16'hFA0B, "hex_f1");
    load_at(b + 5, 16'hFA0B);
    goto(b + 2*FRAME);

    budget = 200;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
